// File: rtl/pc_unit.sv
// IF-stage program counter: next-PC selection (trap > mret > redirect > sequential),
// fetch handshake, stall, halt/resume control and misaligned-redirect detection.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              IALIGN       = 4,
  parameter int              INC          = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            misaligned,
  output logic [XLEN-1:0] misaligned_addr,
  output logic [1:0]      state_out
);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  assign pc_plus_inc = pc_q + INC_V;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;

    case (state_q)
      S_BOOT: state_d = S_RUN;

      S_RUN, S_HALT: begin
        if (trap_valid) begin
          pc_d = TRAP_VECTOR;
        end else if (mret_valid) begin
          pc_d = mepc_in & ~ALIGN_MASK;
        end else if (redirect_valid) begin
          if ((redirect_target & ALIGN_MASK) != '0) begin
            pc_d       = TRAP_VECTOR;
            mis_d      = 1'b1;
            mis_addr_d = redirect_target;
          end else begin
            pc_d = redirect_target;
          end
        end else if (state_q == S_RUN && fetch_ready && !stall) begin
          // pc_valid is implied by S_RUN, so this is the accepted-fetch condition.
          pc_d = pc_plus_inc;
        end

        if (state_q == S_RUN && halt_req)        state_d = S_HALT;
        else if (state_q == S_HALT && resume_req) state_d = S_RUN;
      end

      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign pc_out          = pc_q;
  assign pc_valid        = (state_q == S_RUN);
  assign misaligned      = mis_q;
  assign misaligned_addr = mis_addr_q;
  assign state_out       = state_q;

endmodule
